// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchronise, debounce and edge-strobe the debug-unit buttons and hex switches
module input_conditioner #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int CNT_W     = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        cont,
    input  logic        chk,
    input  logic        ent,
    input  logic        del,
    input  logic [15:0] hd,
    output logic        step_ps,
    output logic        cont_ps,
    output logic        chk_ps,
    output logic        ent_ps,
    output logic        del_ps,
    output logic [15:0] hd_ps,
    output logic [4:0]  btn_db,
    output logic [15:0] hd_db
);

    localparam int N   = 21;
    localparam int NBTN = 5;
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(DB_CYCLES + 1);

    logic [N-1:0]     raw;
    logic [N-1:0]     s1;
    logic [N-1:0]     s2;
    logic [N-1:0]     stable;
    logic [N-1:0]     ps_q;
    logic [CNT_W-1:0] cnt [N];
    logic [CNT_W-1:0] arm_cnt;
    logic             armed;

    // Channel order: buttons in the low bits, switches above them.
    assign raw = {hd, del, ent, chk, cont, step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            stable  <= '0;
            ps_q    <= '0;
            arm_cnt <= '0;
            armed   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Levels already present at reset release settle before this fires, so they never strobe.
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
                if (arm_cnt == ARM_LAST) begin
                    armed <= 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                ps_q[i] <= 1'b0;
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                    ps_q[i]   <= armed && ((i >= NBTN) || s2[i]);
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign step_ps = ps_q[0];
    assign cont_ps = ps_q[1];
    assign chk_ps  = ps_q[2];
    assign ent_ps  = ps_q[3];
    assign del_ps  = ps_q[4];
    assign hd_ps   = ps_q[N-1:NBTN];
    assign btn_db  = stable[NBTN-1:0];
    assign hd_db   = stable[N-1:NBTN];

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - scoreboard bench for input_conditioner
module tb_input_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0, cont = 1'b0, chk = 1'b0, ent = 1'b0, del = 1'b0;
    logic [15:0] hd = 16'h0000;
    logic        step_ps, cont_ps, chk_ps, ent_ps, del_ps;
    logic [15:0] hd_ps;
    logic [4:0]  btn_db;
    logic [15:0] hd_db;

    input_conditioner #(.DB_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .step(step), .cont(cont), .chk(chk), .ent(ent), .del(del), .hd(hd),
        .step_ps(step_ps), .cont_ps(cont_ps), .chk_ps(chk_ps), .ent_ps(ent_ps), .del_ps(del_ps),
        .hd_ps(hd_ps), .btn_db(btn_db), .hd_db(hd_db)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [20:0] ps;
        logic [20:0] db;
    } exp_t;

    exp_t pq[$];
    exp_t lq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input int c, input logic [20:0] p, input logic [20:0] d);
        exp_t e;
        e.cyc = c; e.ps = p; e.db = d;
        pq.push_back(e);
    endtask

    task automatic push_lvl(input int c, input logic [20:0] d);
        exp_t e;
        e.cyc = c; e.ps = '0; e.db = d;
        lq.push_back(e);
    endtask

    // Monitor: vectors are {hd, del, ent, chk, cont, step}
    always @(negedge clk) begin
        logic [20:0] pv, dv;
        exp_t e;
        pv = {hd_ps, del_ps, ent_ps, chk_ps, cont_ps, step_ps};
        dv = {hd_db, btn_db};
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            e = pq.pop_front();
            checks++; failures++;
            $display("FAIL missing_pulse expected at cyc=%0d ps=%h, got no pulse (now cyc=%0d)", e.cyc, e.ps, cyc);
        end
        if (pv != '0) begin
            checks++;
            if (pq.size() == 0 || pq[0].cyc != cyc) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d got ps=%h db=%h, required no pulse", cyc, pv, dv);
            end else begin
                e = pq.pop_front();
                if (e.ps != pv || e.db != dv) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d got ps=%h db=%h, required ps=%h db=%h", cyc, pv, dv, e.ps, e.db);
                end
            end
        end
        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
            e = lq.pop_front();
            checks++;
            if (e.cyc != cyc || e.db != dv || e.ps != pv) begin
                failures++;
                $display("FAIL level cyc=%0d (want cyc=%0d) got db=%h ps=%h, required db=%h ps=%h",
                         cyc, e.cyc, dv, pv, e.db, e.ps);
            end
        end
    end

    initial begin
        int k;
        int r;
        // Reset state
        tick(2);
        push_lvl(cyc, '0);
        tick(1);
        rst = 1'b0;
        tick(10);

        // Clean press and release of step
        step = 1'b1; k = cyc;
        push_lvl(k + 5, '0);
        push_pulse(k + 6, 21'h000001, 21'h000001);
        tick(20);
        step = 1'b0; k = cyc;
        push_lvl(k + 5, 21'h000001);
        push_lvl(k + 6, 21'h000000);
        tick(12);

        // Bouncing chk: only the final run is long enough
        chk = 1'b1; tick(2);
        chk = 1'b0; tick(2);
        chk = 1'b1; tick(2);
        chk = 1'b0; tick(2);
        chk = 1'b1; k = cyc;
        push_lvl(k + 5, '0);
        push_pulse(k + 6, 21'h000004, 21'h000004);
        tick(20);
        chk = 1'b0;
        tick(12);

        // Switch hd[3] both directions
        hd = 16'h0008; k = cyc;
        push_pulse(k + 6, {16'h0008, 5'b0}, {16'h0008, 5'b0});
        tick(12);
        hd = 16'h0000; k = cyc;
        push_pulse(k + 6, {16'h0008, 5'b0}, '0);
        tick(12);

        // Simultaneous press / release
        ent = 1'b1; del = 1'b1; hd = 16'h8001; k = cyc;
        push_pulse(k + 6, {16'h8001, 5'b11000}, {16'h8001, 5'b11000});
        tick(12);
        ent = 1'b0; del = 1'b0; hd = 16'h0000; k = cyc;
        push_pulse(k + 6, {16'h8001, 5'b00000}, '0);
        tick(12);

        // Three-cycle glitch on del
        del = 1'b1; k = cyc;
        tick(3);
        del = 1'b0;
        push_lvl(k + 8, '0);
        tick(12);

        // Asynchronous reset in the middle of a count
        hd = 16'hFFFF; step = 1'b1; k = cyc;
        push_pulse(k + 6, {16'hFFFF, 5'b00001}, {16'hFFFF, 5'b00001});
        tick(8);
        step = 1'b0;
        tick(3);
        #2;
        rst = 1'b1;
        push_lvl(cyc, '0);
        step = 1'b1;
        tick(2);

        // Levels held across release load silently
        rst = 1'b0; r = cyc;
        push_lvl(r + 5, '0);
        push_lvl(r + 6, {16'hFFFF, 5'b00001});
        tick(15);

        checks++;
        if (pq.size() != 0) begin
            failures++;
            $display("FAIL pulse_queue_drain got %0d pending, required 0", pq.size());
        end
        checks++;
        if (lq.size() != 0) begin
            failures++;
            $display("FAIL level_queue_drain got %0d pending, required 0", lq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
